// File: rtl/io_bus_controller.sv
// IO bus controller: req/ack register window with a fixed 2-cycle access latency,
// output port, synchronized input port, sticky rising-edge capture and irq.
module io_bus_controller #(
    parameter int          PORT_W    = 8,
    parameter logic [31:0] IN_ADDR   = 32'd4,
    parameter logic [31:0] OUT_ADDR  = 32'd8,
    parameter logic [31:0] STAT_ADDR = 32'd12,
    parameter logic [31:0] IEN_ADDR  = 32'd16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [31:0]       adress,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              ack,
    output logic              err,
    input  logic [PORT_W-1:0] IO_in,
    output logic [PORT_W-1:0] IO_out,
    output logic              irq
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t state_q, state_d;

    logic [31:0]       addr_q, addr_d;
    logic              we_q, we_d;
    logic [PORT_W-1:0] wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic [PORT_W-1:0] out_q, out_d;
    logic [PORT_W-1:0] ien_q, ien_d;
    logic [PORT_W-1:0] stat_q, stat_d;
    logic [PORT_W-1:0] sync1_q, sync2_q, prev_q;
    logic              irq_q, irq_d;

    logic              hit_in, hit_out, hit_stat, hit_ien;
    logic              mapped, wr_ok;
    logic [PORT_W-1:0] rsel;
    logic [PORT_W-1:0] clr;
    logic [PORT_W-1:0] rise;
    logic              unused_wdata;

    assign unused_wdata = ^wdata[31:PORT_W];

    assign hit_in   = (addr_q == IN_ADDR);
    assign hit_out  = (addr_q == OUT_ADDR);
    assign hit_stat = (addr_q == STAT_ADDR);
    assign hit_ien  = (addr_q == IEN_ADDR);
    assign mapped   = hit_in | hit_out | hit_stat | hit_ien;
    assign wr_ok    = hit_out | hit_stat | hit_ien;

    always_comb begin
        rsel = '0;
        if (hit_in)   rsel = sync2_q;
        if (hit_out)  rsel = out_q;
        if (hit_stat) rsel = stat_q;
        if (hit_ien)  rsel = ien_q;
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = '0;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        out_d   = out_q;
        ien_d   = ien_q;
        clr     = '0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = ACCESS;
                    addr_d  = adress;
                    we_d    = we;
                    wdata_d = wdata[PORT_W-1:0];
                end
            end
            ACCESS: begin
                state_d = RESP;
                ack_d   = 1'b1;
                if (we_q) begin
                    err_d = ~wr_ok;
                    if (hit_out)  out_d = wdata_q;
                    if (hit_ien)  ien_d = wdata_q;
                    if (hit_stat) clr   = wdata_q;
                end else begin
                    err_d   = ~mapped;
                    rdata_d = 32'(rsel);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A fresh edge in the same cycle as a W1C keeps the bit set
    assign rise   = sync2_q & ~prev_q;
    assign stat_d = (stat_q & ~clr) | rise;
    assign irq_d  = |(stat_q & ien_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            out_q   <= '0;
            ien_q   <= '0;
            stat_q  <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            out_q   <= out_d;
            ien_q   <= ien_d;
            stat_q  <= stat_d;
            sync1_q <= IO_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            irq_q   <= irq_d;
        end
    end

    assign rdata  = rdata_q;
    assign ack    = ack_q;
    assign err    = err_q;
    assign IO_out = out_q;
    assign irq    = irq_q;

endmodule

// File: tb/tb_io_bus_controller.sv
// Bench for io_bus_controller: directed steps plus random accesses checked
// against a register-level model of the IO window.
module tb_io_bus_controller;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [31:0] adress;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic        err;
    logic [7:0]  IO_in;
    logic [7:0]  IO_out;
    logic        irq;

    int n_assert;
    int n_fail;

    // model state: settled input value and the architectural registers
    logic [7:0] m_in;
    logic [7:0] m_out;
    logic [7:0] m_stat;
    logic [7:0] m_ien;

    io_bus_controller dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .we     (we),
        .adress (adress),
        .wdata  (wdata),
        .rdata  (rdata),
        .ack    (ack),
        .err    (err),
        .IO_in  (IO_in),
        .IO_out (IO_out),
        .irq    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Change the pins and let synchronizer and edge capture settle
    task automatic set_in(input logic [7:0] v);
        IO_in  = v;
        m_stat = m_stat | (v & ~m_in);
        m_in   = v;
        repeat (4) @(negedge clk);
    endtask

    task automatic access(input logic w, input logic [31:0] a,
                          input logic [31:0] d,
                          output logic [31:0] rd, output logic e);
        int lat;
        lat    = 0;
        req    = 1'b1;
        we     = w;
        adress = a;
        wdata  = d;
        do begin
            @(negedge clk);
            lat++;
        end while (!ack && lat < 8);
        rd  = rdata;
        e   = err;
        req = 1'b0;
        chk("latency", 32'(lat), 32'd2);
        @(negedge clk);
        chk("ack_pulse", {31'd0, ack}, 32'd0);
        chk("rdata_idle", rdata, 32'd0);
    endtask

    task automatic txn(input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [7:0] setm);
        logic [31:0] er;
        logic        ee;
        logic [31:0] rd;
        logic        e;
        er = 32'd0;
        ee = 1'b0;
        if (!w) begin
            case (a)
                32'd4:   er = {24'd0, m_in};
                32'd8:   er = {24'd0, m_out};
                32'd12:  er = {24'd0, m_stat};
                32'd16:  er = {24'd0, m_ien};
                default: ee = 1'b1;
            endcase
        end else begin
            case (a)
                32'd8:   m_out  = d[7:0];
                32'd12:  m_stat = m_stat & ~d[7:0];
                32'd16:  m_ien  = d[7:0];
                default: ee = 1'b1;
            endcase
        end
        m_stat = m_stat | setm;
        access(w, a, d, rd, e);
        chk(w ? "wr_rdata" : "rd_data", rd, er);
        chk(w ? "wr_err" : "rd_err", {31'd0, e}, {31'd0, ee});
        chk("io_out", {24'd0, IO_out}, {24'd0, m_out});
        chk("irq", {31'd0, irq}, {31'd0, |(m_stat & m_ien)});
    endtask

    initial begin
        int acks;
        int first;
        int last;
        logic [31:0] a;

        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        req      = 1'b0;
        we       = 1'b0;
        adress   = 32'd0;
        wdata    = 32'd0;
        IO_in    = 8'd0;
        m_in     = 8'd0;
        m_out    = 8'd0;
        m_stat   = 8'd0;
        m_ien    = 8'd0;

        // reset and idle
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_out", {24'd0, IO_out}, 32'd0);
        acks = 0;
        repeat (10) begin
            @(negedge clk);
            if (ack) acks++;
        end
        chk("idle_acks", 32'(acks), 32'd0);

        // input port read
        set_in(8'hA5);
        txn(1'b0, 32'd4, 32'd0, 8'h00);

        // output write and readback
        txn(1'b1, 32'd8, 32'hFFFF_FF3C, 8'h00);
        txn(1'b0, 32'd8, 32'd0, 8'h00);

        // edge capture, irq timing, W1C
        set_in(8'hA4);
        txn(1'b1, 32'd12, 32'hFF, 8'h00);
        txn(1'b1, 32'd16, 32'h01, 8'h00);
        IO_in  = 8'hA5;
        m_in   = 8'hA5;
        m_stat = 8'h01;
        repeat (3) @(negedge clk);
        chk("irq_early", {31'd0, irq}, 32'd0);
        @(negedge clk);
        chk("irq_edge", {31'd0, irq}, 32'd1);
        txn(1'b0, 32'd12, 32'd0, 8'h00);
        txn(1'b1, 32'd12, 32'h01, 8'h00);

        // edge lands on the W1C commit cycle
        set_in(8'hA4);
        IO_in = 8'hA5;
        m_in  = 8'hA5;
        @(negedge clk);
        txn(1'b1, 32'd12, 32'h01, 8'h01);
        txn(1'b0, 32'd12, 32'd0, 8'h00);

        // errors
        txn(1'b0, 32'd20, 32'd0, 8'h00);
        txn(1'b1, 32'd4, 32'hFF, 8'h00);
        txn(1'b0, 32'd12, 32'd0, 8'h00);

        // req held for 6 cycles
        req    = 1'b1;
        we     = 1'b0;
        adress = 32'd8;
        acks   = 0;
        first  = -1;
        last   = -1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ack) begin
                acks++;
                chk("busy_rdata", rdata, {24'd0, m_out});
                if (first < 0) first = i;
                else last = i;
            end
        end
        req = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (ack) acks++;
        end
        chk("busy_acks", 32'(acks), 32'd2);
        chk("busy_first", 32'(first), 32'd1);
        chk("busy_gap", 32'(last - first), 32'd3);

        // reset during ACCESS of an output write
        req    = 1'b1;
        we     = 1'b1;
        adress = 32'd8;
        wdata  = 32'h55;
        @(negedge clk);
        req   = 1'b0;
        rst_n = 1'b0;
        acks  = 0;
        repeat (2) begin
            @(negedge clk);
            if (ack) acks++;
        end
        rst_n  = 1'b1;
        m_out  = 8'd0;
        m_ien  = 8'd0;
        m_stat = 8'd0;
        m_in   = 8'd0;
        repeat (5) begin
            @(negedge clk);
            if (ack) acks++;
        end
        m_stat = IO_in;
        m_in   = IO_in;
        chk("rst_mid_acks", 32'(acks), 32'd0);
        chk("rst_mid_out", {24'd0, IO_out}, 32'd0);
        txn(1'b0, 32'd12, 32'd0, 8'h00);

        // random accesses
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 2) == 0) set_in(8'($urandom));
            case ($urandom_range(0, 6))
                0:       a = 32'd4;
                1:       a = 32'd8;
                2:       a = 32'd12;
                3:       a = 32'd16;
                4:       a = 32'd0;
                5:       a = 32'h0000_0108;
                default: a = $urandom;
            endcase
            txn(1'($urandom_range(0, 1)), a, $urandom, 8'h00);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/io_bus_controller.md
Name: io_bus_controller

Overview:
- Sequences CPU accesses to the memory-mapped IO register window with a req/ack handshake and a fixed 2-cycle latency.
- Owns the output port register, a 2-flop synchronizer on the input port, sticky rising-edge capture, and an interrupt line.
- Sits between the core's data bus and the external 8-bit IO pins.
- Keeps the input-port read at address 4, so existing firmware is unchanged.

Parameters:
PORT_W, 8, width of the input and output ports
IN_ADDR, 32'd4, read-only: synchronized input port
OUT_ADDR, 32'd8, read/write: output port register
STAT_ADDR, 32'd12, read: edge-capture bits; write: write-1-to-clear
IEN_ADDR, 32'd16, read/write: interrupt enable mask

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
req  in  1  access request; sampled only in IDLE
we  in  1  1 = write, 0 = read; qualified by req
adress  in  32  byte address; qualified by req
wdata  in  32  write data; only bits [PORT_W-1:0] used
rdata  out  32  read data; valid only while ack=1, 0 otherwise
ack  out  1  one-cycle completion pulse
err  out  1  valid with ack; 1 = unmapped address, or write to IN_ADDR
IO_in  in  PORT_W  asynchronous external input pins
IO_out  out  PORT_W  output port register
irq  out  1  registered OR of (status & ien)

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; ack=0, err=0, rdata=0, irq=0.
  - IO_out=0, status=0, ien=0, both synchronizer stages=0, prev-sample=0.
  - Applies mid-transaction: the pending access is dropped, no ack is issued, and no register write takes effect unless it has already been committed in ACCESS.
- FSM has three states: IDLE -> ACCESS -> RESP -> IDLE.
  - IDLE: when req=1, latch adress, we and wdata[PORT_W-1:0], then go to ACCESS. req=0 stays in IDLE.
  - ACCESS: decode the latched address.
    - Writes commit at the end of this cycle.
    - Read data is captured into the rdata register.
    - Go to RESP.
  - RESP: ack=1 and err valid for exactly this cycle; rdata is driven. Return to IDLE.
  - A new req may be accepted in the IDLE cycle that immediately follows RESP.
- Timing and request handling:
  - req sampled high at edge N gives ack=1 during cycle N+2. Throughput is at most one access per 3 cycles.
  - req asserted while in ACCESS or RESP is ignored; it is not queued. The requester holds req until ack if it needs the access served.
- Read data is zero-extended to 32 bits:
  - IN_ADDR: second synchronizer stage.
  - OUT_ADDR: IO_out.
  - STAT_ADDR: status.
  - IEN_ADDR: ien.
  - Unmapped address: 0 with err=1.
- Writes:
  - OUT_ADDR: IO_out <= wdata.
  - IEN_ADDR: ien <= wdata.
  - STAT_ADDR: status bits are cleared where wdata=1.
  - Write to IN_ADDR or to an unmapped address: no state change, err=1.
- Synchronizer and edge capture:
  - IO_in passes through two flops (sync1, sync2).
  - prev <= sync2 every cycle.
  - Rising edge on bit i is (sync2[i] & ~prev[i]), which sets status[i]. Status bits are sticky.
  - The edge is therefore seen 3 cycles after IO_in changes, counting the sync2 update plus the compare.
  - If an edge-set and a W1C hit the same bit in the same cycle, set wins (status stays 1).
  - Falling edges are ignored.
- irq <= |(status & ien), registered, so irq lags status by 1 cycle. Clearing status or ien drops irq one cycle after that change.
- Decode compares the full 32-bit address; no aliasing and no partial decode.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles, then release -> all outputs 0. With req=0 for 10 cycles, ack never rises.
- Read input: IO_in=8'hA5 held for 4 cycles, then req, we=0, adress=4 at edge N -> ack=1 at N+2 only, rdata=32'h000000A5, err=0. rdata=0 at N+3.
- Write/readback output: write adress=8, wdata=32'hFFFF_FF3C -> IO_out=8'h3C after ACCESS. Reading adress=8 then returns 32'h0000003C.
- Edge capture and irq:
  - Setup: write ien=8'h01.
  - Stimulus: drive IO_in[0] 0->1.
  - Required: status[0]=1 three cycles later and irq=1 one cycle after that. Reading adress=12 returns 32'h1.
  - Then write 1 to adress=12 -> status[0]=0 and irq=0 the next cycle.
  - Collision case: time a fresh edge on bit 0 to coincide with the W1C -> status[0] stays 1.
- Errors: read adress=20 -> ack with rdata=0, err=1. Write adress=4 -> ack, err=1, IO_out and status unchanged.
- Busy/reset mid-op: hold req=1 for 6 consecutive cycles -> exactly two acks, 3 cycles apart. Assert rst_n=0 during ACCESS of a write to OUT_ADDR -> no ack and IO_out=0.
